// File: rtl/fpu_bridge_pkg.sv
// Shared constants, FSM state type and byte-merge helper for the Wishbone-to-FPU bridge.
package fpu_bridge_pkg;

  localparam logic [4:0] OFF_OPA    = 5'h00;
  localparam logic [4:0] OFF_OPB    = 5'h04;
  localparam logic [4:0] OFF_CTRL   = 5'h08;
  localparam logic [4:0] OFF_STATUS = 5'h0C;
  localparam logic [4:0] OFF_RESULT = 5'h10;

  localparam int unsigned CTRL_OP_LSB = 0;
  localparam int unsigned CTRL_START  = 2;
  localparam int unsigned CTRL_IRQ_EN = 3;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_DONE    = 1;
  localparam int unsigned ST_TIMEOUT = 2;
  localparam int unsigned ST_WR_BUSY = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    WAIT_Z = 3'd3,
    ACK_Z  = 3'd4
  } fsm_state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = sel[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_fpu_bridge_if.sv
// Wishbone slave bus plus FPU operand/result handshake, grouped for the bridge boundary.
interface wb_fpu_bridge_if;

  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  logic [31:0] fpu_in;
  logic        fpu_input_a_stb;
  logic        fpu_input_a_ack;
  logic        fpu_input_b_stb;
  logic        fpu_input_b_ack;
  logic [1:0]  fpu_op_sel;
  logic [31:0] fpu_output_z;
  logic        fpu_output_z_stb;
  logic        fpu_output_z_ack;
  logic        irq;

  // Bridge side.
  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output fpu_in, fpu_input_a_stb, fpu_input_b_stb, fpu_op_sel, fpu_output_z_ack,
    input  fpu_input_a_ack, fpu_input_b_ack, fpu_output_z, fpu_output_z_stb,
    output irq
  );

  // Bus master / FPU side.
  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  fpu_in, fpu_input_a_stb, fpu_input_b_stb, fpu_op_sel, fpu_output_z_ack,
    output fpu_input_a_ack, fpu_input_b_ack, fpu_output_z, fpu_output_z_stb,
    input  irq
  );

endinterface

// File: rtl/fpu_handshake_seq.sv
// Streams the operand snapshot A then B to the FPU, collects Z, and aborts on timeout.
module fpu_handshake_seq
  import fpu_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_opa,
  input  logic [31:0] i_opb,
  input  logic [1:0]  i_op_sel,
  input  logic        i_a_ack,
  input  logic        i_b_ack,
  input  logic [31:0] i_z,
  input  logic        i_z_stb,
  output logic [31:0] o_fpu_in,
  output logic        o_a_stb,
  output logic        o_b_stb,
  output logic        o_z_ack,
  output logic [1:0]  o_op_sel,
  output logic        o_busy,
  output logic        o_res_we,
  output logic [31:0] o_res_data,
  output logic        o_done_set,
  output logic        o_to_set
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  fsm_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_fpu_in;
  logic [31:0]      r_opb;
  logic [1:0]       r_op_sel;
  logic             r_a_stb;
  logic             r_b_stb;
  logic             r_z_ack;

  logic w_counting;
  logic w_hs;
  logic w_to_hit;
  logic w_to_fire;

  always_comb begin
    w_counting = (r_state == SEND_A) || (r_state == SEND_B) || (r_state == WAIT_Z);
    w_hs       = ((r_state == SEND_A) && i_a_ack) ||
                 ((r_state == SEND_B) && i_b_ack) ||
                 ((r_state == WAIT_Z) && i_z_stb);
    w_to_hit   = (TIMEOUT != 0) && (r_cnt == TO_LAST);
    // A handshake landing on the last allowed cycle beats the abort.
    w_to_fire  = w_counting && w_to_hit && !w_hs;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_fpu_in <= '0;
      r_opb    <= '0;
      r_op_sel <= '0;
      r_a_stb  <= 1'b0;
      r_b_stb  <= 1'b0;
      r_z_ack  <= 1'b0;
    end else begin
      if (w_counting && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_to_fire) begin
        r_state  <= IDLE;
        r_a_stb  <= 1'b0;
        r_b_stb  <= 1'b0;
        r_z_ack  <= 1'b0;
        r_fpu_in <= '0;
        r_op_sel <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_start) begin
              r_state  <= SEND_A;
              r_fpu_in <= i_opa;
              r_opb    <= i_opb;
              r_op_sel <= i_op_sel;
              r_a_stb  <= 1'b1;
              r_cnt    <= '0;
            end
          end
          SEND_A: begin
            if (i_a_ack) begin
              r_state  <= SEND_B;
              r_a_stb  <= 1'b0;
              r_b_stb  <= 1'b1;
              r_fpu_in <= r_opb;
            end
          end
          SEND_B: begin
            if (i_b_ack) begin
              r_state  <= WAIT_Z;
              r_b_stb  <= 1'b0;
              r_fpu_in <= '0;
            end
          end
          WAIT_Z: begin
            if (i_z_stb) begin
              r_state <= ACK_Z;
              r_z_ack <= 1'b1;
            end
          end
          ACK_Z: begin
            r_state  <= IDLE;
            r_z_ack  <= 1'b0;
            r_op_sel <= '0;
          end
          default: begin
            r_state  <= IDLE;
            r_a_stb  <= 1'b0;
            r_b_stb  <= 1'b0;
            r_z_ack  <= 1'b0;
            r_fpu_in <= '0;
            r_op_sel <= '0;
          end
        endcase
      end
    end
  end

  assign o_fpu_in   = r_fpu_in;
  assign o_a_stb    = r_a_stb;
  assign o_b_stb    = r_b_stb;
  assign o_z_ack    = r_z_ack;
  assign o_op_sel   = r_op_sel;
  assign o_busy     = (r_state != IDLE);
  assign o_res_we   = (r_state == WAIT_Z) && i_z_stb;
  assign o_res_data = i_z;
  assign o_done_set = (r_state == ACK_Z);
  assign o_to_set   = w_to_fire;

endmodule

// File: rtl/wb_fpu_bridge.sv
// Wishbone register file (OPA/OPB/CTRL/STATUS/RESULT) in front of the FPU handshake sequencer.
module wb_fpu_bridge
  import fpu_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input logic            clk,
  input logic            reset_n,
  wb_fpu_bridge_if.slave bus
);

  logic        r_ack;
  logic [31:0] r_rdata;
  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic [31:0] r_result;
  logic [1:0]  r_op_sel;
  logic        r_irq_en;
  logic        r_done;
  logic        r_to_err;
  logic        r_wbe;

  logic        w_req;
  logic        w_wr;
  logic        w_rd;
  logic [4:0]  w_off;
  logic        w_wr_opa;
  logic        w_wr_opb;
  logic        w_wr_ctrl;
  logic        w_wbe_set;
  logic        w_start;
  logic [3:1]  w_st_clr;
  logic        w_res_rd;
  logic [31:0] w_rmux;
  logic        w_unused_adr;

  logic [31:0] w_fpu_in;
  logic        w_a_stb;
  logic        w_b_stb;
  logic        w_z_ack;
  logic [1:0]  w_op_sel;
  logic        w_busy;
  logic        w_res_we;
  logic [31:0] w_res_data;
  logic        w_done_set;
  logic        w_to_set;

  assign w_req = bus.wbs_stb_i && bus.wbs_cyc_i &&
                 (bus.wbs_adr_i[31:8] == BASE_ADDR[31:8]) && !r_ack;
  assign w_wr  = w_req && bus.wbs_we_i;
  assign w_rd  = w_req && !bus.wbs_we_i;
  assign w_off = {bus.wbs_adr_i[4:2], 2'b00};

  assign w_unused_adr = ^{bus.wbs_adr_i[7:5], bus.wbs_adr_i[1:0]};

  assign w_wr_opa  = w_wr && (w_off == OFF_OPA);
  assign w_wr_opb  = w_wr && (w_off == OFF_OPB);
  assign w_wr_ctrl = w_wr && (w_off == OFF_CTRL);
  assign w_wbe_set = (w_wr_opa || w_wr_opb || w_wr_ctrl) && w_busy;
  assign w_start   = w_wr_ctrl && bus.wbs_sel_i[0] && bus.wbs_dat_i[CTRL_START] && !w_busy;
  assign w_st_clr  = (w_wr && (w_off == OFF_STATUS) && bus.wbs_sel_i[0]) ?
                     bus.wbs_dat_i[3:1] : 3'b000;
  assign w_res_rd  = w_rd && (w_off == OFF_RESULT);

  always_comb begin
    w_rmux = '0;
    case (w_off)
      OFF_OPA:    w_rmux = r_opa;
      OFF_OPB:    w_rmux = r_opb;
      OFF_CTRL:   w_rmux = {28'd0, r_irq_en, 1'b0, r_op_sel};
      OFF_STATUS: w_rmux = {28'd0, r_wbe, r_to_err, r_done, w_busy};
      OFF_RESULT: w_rmux = r_result;
      default:    w_rmux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack    <= 1'b0;
      r_rdata  <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_op_sel <= '0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_to_err <= 1'b0;
      r_wbe    <= 1'b0;
    end else begin
      r_ack   <= w_req;
      // Read data only carries a value in the ack cycle.
      r_rdata <= w_rd ? w_rmux : '0;
      if (w_wr_opa && !w_busy) begin
        r_opa <= byte_merge(r_opa, bus.wbs_dat_i, bus.wbs_sel_i);
      end
      if (w_wr_opb && !w_busy) begin
        r_opb <= byte_merge(r_opb, bus.wbs_dat_i, bus.wbs_sel_i);
      end
      if (w_wr_ctrl && !w_busy && bus.wbs_sel_i[0]) begin
        r_op_sel <= bus.wbs_dat_i[CTRL_OP_LSB +: 2];
        r_irq_en <= bus.wbs_dat_i[CTRL_IRQ_EN];
      end
      if (w_res_we) begin
        r_result <= w_res_data;
      end
      // Hardware set takes priority over every clear source.
      r_done   <= w_done_set || (r_done && !w_start && !w_st_clr[ST_DONE] && !w_res_rd);
      r_to_err <= w_to_set || (r_to_err && !w_start && !w_st_clr[ST_TIMEOUT]);
      r_wbe    <= w_wbe_set || (r_wbe && !w_st_clr[ST_WR_BUSY]);
    end
  end

  fpu_handshake_seq #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_seq (
    .i_clk      (clk),
    .i_rst_n    (reset_n),
    .i_start    (w_start),
    .i_opa      (r_opa),
    .i_opb      (r_opb),
    .i_op_sel   (bus.wbs_dat_i[CTRL_OP_LSB +: 2]),
    .i_a_ack    (bus.fpu_input_a_ack),
    .i_b_ack    (bus.fpu_input_b_ack),
    .i_z        (bus.fpu_output_z),
    .i_z_stb    (bus.fpu_output_z_stb),
    .o_fpu_in   (w_fpu_in),
    .o_a_stb    (w_a_stb),
    .o_b_stb    (w_b_stb),
    .o_z_ack    (w_z_ack),
    .o_op_sel   (w_op_sel),
    .o_busy     (w_busy),
    .o_res_we   (w_res_we),
    .o_res_data (w_res_data),
    .o_done_set (w_done_set),
    .o_to_set   (w_to_set)
  );

  assign bus.wbs_ack_o        = r_ack;
  assign bus.wbs_dat_o        = r_rdata;
  assign bus.fpu_in           = w_fpu_in;
  assign bus.fpu_input_a_stb  = w_a_stb;
  assign bus.fpu_input_b_stb  = w_b_stb;
  assign bus.fpu_output_z_ack = w_z_ack;
  assign bus.fpu_op_sel       = w_op_sel;
  assign bus.irq              = r_irq_en && (r_done || r_to_err);

endmodule

// File: tb/tb_wb_fpu_bridge.sv
// Directed bench for wb_fpu_bridge: small FPU model, result scoreboard, immediate assertions.
module tb_wb_fpu_bridge;
  import fpu_bridge_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  wb_fpu_bridge_if bus_if ();

  wb_fpu_bridge #(
    .BASE_ADDR (BASE),
    .TIMEOUT   (16),
    .CNT_W     (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  // FPU model: A/B acked 2 cycles after stb, Z presented 10 cycles into the operation.
  bit          m_a_en;
  int          m_ph_cnt;
  int          m_op_cyc;
  bit          m_z_wait;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [1:0]  m_op;

  function automatic logic [31:0] fpu_ref(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    if (op == 2'd0 && a == 32'h3FC0_0000 && b == 32'h4010_0000) return 32'h4070_0000;
    if (op == 2'd2 && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return a ^ b;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_if.fpu_input_a_ack  <= 1'b0;
      bus_if.fpu_input_b_ack  <= 1'b0;
      bus_if.fpu_output_z_stb <= 1'b0;
      bus_if.fpu_output_z     <= '0;
      m_ph_cnt <= 0;
      m_op_cyc <= 0;
      m_z_wait <= 1'b0;
      m_a      <= '0;
      m_b      <= '0;
      m_op     <= '0;
    end else begin
      bus_if.fpu_input_a_ack <= 1'b0;
      bus_if.fpu_input_b_ack <= 1'b0;
      if (!bus_if.fpu_input_a_stb && !bus_if.fpu_input_b_stb) m_ph_cnt <= 0;
      if (bus_if.fpu_input_a_stb || bus_if.fpu_input_b_stb || m_z_wait) m_op_cyc <= m_op_cyc + 1;
      else m_op_cyc <= 0;
      if (bus_if.fpu_input_a_stb && !bus_if.fpu_input_a_ack) begin
        if (m_ph_cnt == 1 && m_a_en) begin
          bus_if.fpu_input_a_ack <= 1'b1;
          m_ph_cnt <= 0;
        end else m_ph_cnt <= m_ph_cnt + 1;
      end
      if (bus_if.fpu_input_a_stb && bus_if.fpu_input_a_ack) begin
        m_a      <= bus_if.fpu_in;
        m_op     <= bus_if.fpu_op_sel;
        m_ph_cnt <= 0;
      end
      if (bus_if.fpu_input_b_stb && !bus_if.fpu_input_b_ack) begin
        if (m_ph_cnt == 1) begin
          bus_if.fpu_input_b_ack <= 1'b1;
          m_ph_cnt <= 0;
        end else m_ph_cnt <= m_ph_cnt + 1;
      end
      if (bus_if.fpu_input_b_stb && bus_if.fpu_input_b_ack) begin
        m_b      <= bus_if.fpu_in;
        m_z_wait <= 1'b1;
      end
      if (m_z_wait && !bus_if.fpu_output_z_stb && m_op_cyc >= 9) begin
        bus_if.fpu_output_z_stb <= 1'b1;
        bus_if.fpu_output_z     <= fpu_ref(m_op, m_a, m_b);
      end
      if (bus_if.fpu_output_z_stb && bus_if.fpu_output_z_ack) begin
        bus_if.fpu_output_z_stb <= 1'b0;
        bus_if.fpu_output_z     <= '0;
        m_z_wait <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         input logic [3:0] sel, output logic [31:0] rdat, output bit acked);
    @(posedge clk); #1;
    bus_if.wbs_stb_i = 1'b1;
    bus_if.wbs_cyc_i = 1'b1;
    bus_if.wbs_we_i  = we;
    bus_if.wbs_adr_i = adr;
    bus_if.wbs_dat_i = wdat;
    bus_if.wbs_sel_i = sel;
    acked = 1'b0;
    rdat  = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus_if.wbs_ack_o) begin
        acked = 1'b1;
        rdat  = bus_if.wbs_dat_o;
        break;
      end
    end
    bus_if.wbs_stb_i = 1'b0;
    bus_if.wbs_cyc_i = 1'b0;
    bus_if.wbs_we_i  = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [4:0] off, input logic [31:0] d,
                    input logic [3:0] sel);
    logic [31:0] rd_unused;
    bit          ak;
    wb_xfer(1'b1, BASE + 32'(off), d, sel, rd_unused, ak);
    check({tag, "_ack"}, 32'(ak), 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] off, input logic [31:0] exp);
    logic [31:0] d;
    bit          ak;
    wb_xfer(1'b0, BASE + 32'(off), '0, 4'hF, d, ak);
    check({tag, "_ack"}, 32'(ak), 32'd1);
    check(tag, d, exp);
  endtask

  task automatic rd_result(input string tag);
    logic [31:0] d;
    logic [31:0] exp;
    bit          ak;
    wb_xfer(1'b0, BASE + 32'(OFF_RESULT), '0, 4'hF, d, ak);
    check({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check(tag, d, exp);
  endtask

  // Observes one operation from the cycle after the start ack until irq (done) rises.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input bit busy_wr);
    int          first_a = -1;
    int          first_b = -1;
    int          zack_n  = 0;
    int          op_bad  = 0;
    logic [31:0] in_a    = '0;
    logic [31:0] in_b    = '0;
    bit          fin     = 1'b0;
    bit          wrote   = 1'b0;
    logic [31:0] d;
    bit          ak;
    for (int i = 0; i < 60 && !fin; i++) begin
      @(negedge clk);
      if (bus_if.fpu_input_a_stb && first_a < 0) begin
        first_a = i;
        in_a    = bus_if.fpu_in;
      end
      if (bus_if.fpu_input_b_stb && first_b < 0) begin
        first_b = i;
        in_b    = bus_if.fpu_in;
      end
      if (bus_if.fpu_output_z_ack) zack_n++;
      if (bus_if.irq) fin = 1'b1;
      else if (bus_if.fpu_op_sel !== op) op_bad++;
      if (busy_wr && !wrote && bus_if.fpu_input_b_stb && bus_if.fpu_input_b_ack) begin
        wrote = 1'b1;
        wb_xfer(1'b1, BASE + 32'(OFF_OPA), 32'h1234_5678, 4'hF, d, ak);
        check({tag, "_busy_wr_ack"}, 32'(ak), 32'd1);
      end
    end
    check({tag, "_done"}, 32'(fin), 32'd1);
    check({tag, "_a_first_cycle"}, 32'(first_a), 32'd0);
    check({tag, "_a_before_b"}, 32'(first_b > first_a), 32'd1);
    check({tag, "_in_a"}, in_a, a);
    check({tag, "_in_b"}, in_b, b);
    check({tag, "_zack_len"}, 32'(zack_n), 32'd1);
    check({tag, "_op_stable"}, 32'(op_bad), 32'd0);
    check({tag, "_op_idle"}, 32'(bus_if.fpu_op_sel), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    bit          ak;
    int          n;

    reset_n          = 1'b0;
    m_a_en           = 1'b1;
    bus_if.wbs_stb_i = 1'b0;
    bus_if.wbs_cyc_i = 1'b0;
    bus_if.wbs_we_i  = 1'b0;
    bus_if.wbs_sel_i = '0;
    bus_if.wbs_adr_i = '0;
    bus_if.wbs_dat_i = '0;
    #12;
    check("rst_a_stb", 32'(bus_if.fpu_input_a_stb), 32'd0);
    check("rst_fpu_in", bus_if.fpu_in, 32'd0);
    check("rst_irq", 32'(bus_if.irq), 32'd0);
    check("rst_ack", 32'(bus_if.wbs_ack_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_chk("rst_status", OFF_STATUS, 32'd0);

    // Add.
    wr("add_opa", OFF_OPA, 32'h3FC0_0000, 4'hF);
    wr("add_opb", OFF_OPB, 32'h4010_0000, 4'hF);
    exp_q.push_back(32'h4070_0000);
    wr("add_ctrl", OFF_CTRL, 32'h1C, 4'hF);
    run_op("add", 32'h3FC0_0000, 32'h4010_0000, 2'd0, 1'b0);
    rd_chk("add_status", OFF_STATUS, 32'h2);
    check("add_irq", 32'(bus_if.irq), 32'd1);
    rd_result("add_result");
    check("add_irq_clr", 32'(bus_if.irq), 32'd0);
    rd_chk("add_status_clr", OFF_STATUS, 32'h0);

    // Multiply.
    wr("mul_opa", OFF_OPA, 32'h4000_0000, 4'hF);
    wr("mul_opb", OFF_OPB, 32'h4040_0000, 4'hF);
    exp_q.push_back(32'h40C0_0000);
    wr("mul_ctrl", OFF_CTRL, 32'h0E, 4'hF);
    run_op("mul", 32'h4000_0000, 32'h4040_0000, 2'd2, 1'b0);
    rd_result("mul_result");

    // Write to OPA while waiting for Z.
    wr("wbz_opa", OFF_OPA, 32'h3FC0_0000, 4'hF);
    wr("wbz_opb", OFF_OPB, 32'h4010_0000, 4'hF);
    exp_q.push_back(32'h4070_0000);
    wr("wbz_ctrl", OFF_CTRL, 32'h1C, 4'hF);
    run_op("wbz", 32'h3FC0_0000, 32'h4010_0000, 2'd0, 1'b1);
    rd_chk("wbz_status", OFF_STATUS, 32'hA);
    rd_result("wbz_result");
    rd_chk("wbz_opa_kept", OFF_OPA, 32'h3FC0_0000);
    wr("wbz_w1c", OFF_STATUS, 32'h8, 4'hF);
    rd_chk("wbz_status_clr", OFF_STATUS, 32'h0);

    // Timeout: A is never accepted.
    m_a_en = 1'b0;
    wr("to_ctrl", OFF_CTRL, 32'h0C, 4'hF);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_if.fpu_input_a_stb) n++;
      else break;
    end
    check("to_a_stb_cycles", 32'(n), 32'd16);
    m_a_en = 1'b1;
    rd_chk("to_status", OFF_STATUS, 32'h4);
    check("to_irq", 32'(bus_if.irq), 32'd1);
    rd_chk("to_result_kept", OFF_RESULT, 32'h4070_0000);
    wr("to_w1c", OFF_STATUS, 32'h4, 4'hF);
    rd_chk("to_status_clr", OFF_STATUS, 32'h0);

    // Reset in SEND_B.
    wr("rst_ctrl", OFF_CTRL, 32'h0E, 4'hF);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.fpu_input_b_stb) begin
        n = 1;
        break;
      end
    end
    check("rst_reached_b", 32'(n), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_b_stb", 32'(bus_if.fpu_input_b_stb), 32'd0);
    check("arst_fpu_in", bus_if.fpu_in, 32'd0);
    check("arst_op_sel", 32'(bus_if.fpu_op_sel), 32'd0);
    check("arst_irq", 32'(bus_if.irq), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_chk("arst_opa", OFF_OPA, 32'h0);
    wr("post_opa", OFF_OPA, 32'h3FC0_0000, 4'hF);
    wr("post_opb", OFF_OPB, 32'h4010_0000, 4'hF);
    exp_q.push_back(32'h4070_0000);
    wr("post_ctrl", OFF_CTRL, 32'h1C, 4'hF);
    run_op("post", 32'h3FC0_0000, 32'h4010_0000, 2'd0, 1'b0);
    rd_result("post_result");

    // Byte selects and decode.
    wr("bs_clr", OFF_OPA, 32'h0, 4'hF);
    wr("bs_wr", OFF_OPA, 32'hAABB_CCDD, 4'b0101);
    rd_chk("bs_opa", OFF_OPA, 32'h00BB_00DD);
    rd_chk("unmapped_18", 5'h18, 32'h0);
    wb_xfer(1'b0, 32'h3000_0100, '0, 4'hF, d, ak);
    check("nomatch_ack", 32'(ak), 32'd0);
    check("nomatch_dat", d, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
